// File: rtl/nco_iq_pipe.sv
// Pipelined I/Q NCO: phase accumulator, folded quarter-wave table, sign stage.
// Optional phase dither on the table address when NCO_PHASE_DITHER_EN is defined.
module nco_iq_pipe #(
    parameter int DW    = 16,
    parameter int PW    = 32,
    parameter int ABITS = 10,
    parameter int SCALE = 32767,
    parameter logic [PW-1:0] FTW_RESET = PW'(1) << (PW - ABITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] ftw_in,
    input  logic          ftw_load,
    input  logic          phase_clr,
    input  logic          next_sample,
    output logic [DW-1:0] inphase_sample,
    output logic [DW-1:0] quadrature_sample,
    output logic          sample_valid,
    output logic          phase_wrap
);
    localparam int  QB     = ABITS - 2;
    localparam int  QN     = 1 << QB;
    localparam int  STAGES = 2;
    localparam real PI     = 3.14159265358979323846;

    function automatic logic [DW-1:0] qsin_val(input int k);
        real a;
        a = $sin(PI / 2.0 * (real'(k) + 0.5) / real'(QN)) * real'(SCALE);
        return DW'($rtoi(a + 0.5));
    endfunction

    // Half-step sample points make entry k and entry QN-1-k mirror exactly.
    logic [DW-1:0] rom [QN];
    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam logic [DW-1:0] V = qsin_val(k);
        assign rom[k] = V;
    end

    logic [PW-1:0]     acc, ftw, p_r;
    logic [PW:0]       sum;
    logic [STAGES:0]   vld_pipe, wrap_pipe;

    // phase_clr with a request restarts from zero, so the increment base is zero.
    assign sum = {1'b0, (phase_clr ? '0 : acc)} + {1'b0, ftw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            ftw       <= FTW_RESET;
            vld_pipe  <= '0;
            wrap_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], next_sample};
            wrap_pipe <= {wrap_pipe[STAGES-1:0], next_sample & sum[PW]};
            if (ftw_load)
                ftw <= ftw_in;
            if (next_sample)
                acc <= sum[PW-1:0];
            else if (phase_clr)
                acc <= '0;
        end
    end

    always_ff @(posedge clk)
        if (next_sample)
            p_r <= phase_clr ? '0 : acc;

    logic [PW-1:0] aphase;
`ifdef NCO_PHASE_DITHER_EN
    localparam int DB = (PW - ABITS < 16) ? PW - ABITS : 16;
    logic [15:0] lfsr, d_r;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr <= 16'hACE1;
        else if (next_sample)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    always_ff @(posedge clk)
        if (next_sample)
            d_r <= lfsr;

    assign aphase = p_r + (PW'(d_r[15 -: DB]) << (PW - ABITS - DB));
`else
    assign aphase = p_r;
`endif

    // Port 0 is Q (sine), port 1 is I (cosine = sine advanced a quarter turn).
    logic [1:0][ABITS-1:0] idx;
    logic [1:0][QB-1:0]    addr;
    logic [1:0]            neg, neg_r;
    logic [1:0][DW-1:0]    rd;

    assign idx[0] = aphase[PW-1 -: ABITS];
    assign idx[1] = aphase[PW-1 -: ABITS] + ABITS'(QN);

    always_comb begin
        addr = '0;
        neg  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            addr[ch] = idx[ch][QB] ? ~idx[ch][QB-1:0] : idx[ch][QB-1:0];
            neg[ch]  = idx[ch][ABITS-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            rd[ch]    <= rom[addr[ch]];
            neg_r[ch] <= neg[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quadrature_sample <= '0;
            inphase_sample    <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            quadrature_sample <= neg_r[0] ? -rd[0] : rd[0];
            inphase_sample    <= neg_r[1] ? -rd[1] : rd[1];
        end
    end

    assign sample_valid = vld_pipe[STAGES];
    assign phase_wrap   = wrap_pipe[STAGES];
endmodule

// File: tb/tb_nco_iq_pipe.sv
// Directed bench for nco_iq_pipe with a trigonometric reference model and
// a per-cycle output checker.
module tb_nco_iq_pipe;
    localparam int  DW = 16, PW = 32, ABITS = 10, SCALE = 32767;
    localparam logic [PW-1:0] FTW_DEF = 32'h0040_0000;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 0, rst_n = 0, ftw_load = 0, phase_clr = 0, next_sample = 0;
    logic [PW-1:0] ftw_in = '0;
    logic [DW-1:0] isamp, qsamp;
    logic          sv, pw;

    always #5 clk = ~clk;

    nco_iq_pipe #(.DW(DW), .PW(PW), .ABITS(ABITS), .SCALE(SCALE)) dut (
        .clk(clk), .rst_n(rst_n), .ftw_in(ftw_in), .ftw_load(ftw_load),
        .phase_clr(phase_clr), .next_sample(next_sample),
        .inphase_sample(isamp), .quadrature_sample(qsamp),
        .sample_valid(sv), .phase_wrap(pw));

    int checks = 0, failures = 0, cyc = 0;
    typedef struct { int due; int i; int q; bit w; } exp_t;
    exp_t expq[$];

    logic [PW-1:0] m_acc = '0, m_ftw = FTW_DEF;
    logic [15:0]   m_lfsr = 16'hACE1;
    int rst_cyc = -10, held_i = 0, held_q = 0, last_i = 0, last_q = 0;
    bit chk_en = 0, last_w = 0;
    bit dwin = 0, s101 = 0, s302 = 0, sother = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Full-wave value at the midpoint of the table cell the phase falls in.
    function automatic int wave(input logic [PW-1:0] ap, input bit cosine);
        real th;
        th = 2.0 * PI * (real'(ap[PW-1 -: ABITS]) + 0.5) / real'(1 << ABITS);
        return rnd(real'(SCALE) * (cosine ? $cos(th) : $sin(th)));
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic drive(input bit ns, input bit clr, input bit ld,
                         input logic [PW-1:0] f, input bit rst);
        logic [PW:0]   s;
        logic [PW-1:0] p, ap;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; next_sample = ns; phase_clr = clr; ftw_load = ld; ftw_in = f;
        if (!rst) begin
            m_acc = '0; m_ftw = FTW_DEF; m_lfsr = 16'hACE1;
            while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
            rst_cyc = cyc;
        end else begin
            if (ns) begin
                p  = clr ? '0 : m_acc;
                s  = {1'b0, p} + {1'b0, m_ftw};
                ap = p;
`ifdef NCO_PHASE_DITHER_EN
                ap = p + (PW'(m_lfsr) << (PW - ABITS - 16));
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
                e.due = cyc + 3; e.q = wave(ap, 0); e.i = wave(ap, 1); e.w = s[PW];
                expq.push_back(e);
                m_acc = s[PW-1:0];
            end else if (clr) m_acc = '0;
            if (ld) m_ftw = f;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, '0, 1);
    endtask

    task automatic req(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 0, '0, 1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_cyc + 1) begin held_i = 0; held_q = 0; end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                exp_t e;
                e = expq.pop_front();
                if (sv !== 1'b1 || pw !== e.w || $signed(isamp) != e.i || $signed(qsamp) != e.q) begin
                    failures++;
                    $display("FAIL sample cyc=%0d got v=%0b w=%0b I=%0d Q=%0d expected v=1 w=%0b I=%0d Q=%0d",
                             cyc, sv, pw, $signed(isamp), $signed(qsamp), e.w, e.i, e.q);
                end
                held_i = e.i; held_q = e.q;
                last_i = $signed(isamp); last_q = $signed(qsamp); last_w = pw;
                if (dwin) begin
                    if (last_q == 101) s101 = 1;
                    else if (last_q == 302) s302 = 1;
                    else sother = 1;
                end
            end else if (sv !== 1'b0 || pw !== 1'b0 || $signed(isamp) != held_i || $signed(qsamp) != held_q) begin
                failures++;
                $display("FAIL idle cyc=%0d got v=%0b w=%0b I=%0d Q=%0d expected v=0 w=0 I=%0d Q=%0d",
                         cyc, sv, pw, $signed(isamp), $signed(qsamp), held_i, held_q);
            end
        end
    end

    initial begin
        // Hand-computed table points pin the reference model.
        check("model_q0",   wave(32'h0000_0000, 0), 101);
        check("model_i0",   wave(32'h0000_0000, 1), 32767);
        check("model_q1",   wave(32'h0040_0000, 0), 302);
        check("model_q255", wave(32'h3FC0_0000, 0), 32767);
        check("model_q512", wave(32'h8000_0000, 0), -101);
        check("model_i512", wave(32'h8000_0000, 1), -32767);

        drive(0, 0, 0, '0, 0);
        drive(0, 0, 0, '0, 0);
        chk_en = 1;

        // Single request after reset
        drive(1, 0, 0, '0, 1);
        idle(4);
        check("t1_q", last_q, 101);
        check("t1_i", last_i, 32767);
        check("t1_wrap", int'(last_w), 0);

        // Full turn and beyond at the default step
        drive(0, 1, 0, '0, 1);
        req(1030);
        idle(4);

        // Quarter-turn step loaded alongside a request
        drive(0, 1, 0, '0, 1);
        drive(1, 0, 1, 32'h4000_0000, 1);
        req(12);

        // phase_clr mid-stream
        drive(1, 1, 0, '0, 1);
        req(3);
        idle(4);

        // ftw = 0 gives constant samples without wrap
        drive(1, 0, 1, '0, 1);
        req(6);
        idle(4);

        // Reset with two samples in flight
        drive(1, 0, 0, '0, 1);
        drive(1, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 0);
        idle(4);
        check("t5_q_zero", $signed(qsamp), 0);
        check("t5_i_zero", $signed(isamp), 0);
        drive(1, 0, 0, '0, 1);
        idle(4);
        check("t5_q", last_q, 101);
        check("t5_i", last_i, 32767);

`ifdef NCO_PHASE_DITHER_EN
        drive(0, 1, 1, 32'h0020_0000, 1);
        dwin = 1;
        for (int k = 0; k < 32; k++) begin
            drive(1, 1, 0, '0, 1);
            drive(1, 0, 0, '0, 1);
        end
        idle(4);
        dwin = 0;
        check("t6_seen101", int'(s101), 1);
        check("t6_seen302", int'(s302), 1);
        check("t6_other", int'(sother), 0);
`endif

        idle(6);
        check("drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
